// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
// The command and response widths follow the SPI master's start/data_in/data_out interface.
package spi_arb_pkg;

  localparam int CMD_W = 10;
  localparam int RSP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester-side and SPI-master-side handshake signals of the arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding logic's view.
interface spi_master_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CMD_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [RSP_W-1:0]         rsp_data;
  logic                     rsp_err;

  logic                     m_start;
  logic [CMD_W-1:0]         m_data_in;
  logic                     m_busy;
  logic                     m_done;
  logic [RSP_W-1:0]         m_data_out;

  modport master (
    input  req_valid, req_data, m_busy, m_done, m_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, m_start, m_data_in
  );

  modport slave (
    output req_valid, req_data, m_busy, m_done, m_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, m_start, m_data_in
  );

endinterface

// File: rtl/spi_master_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request at or above rr_ptr,
// wrapping at NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic found;
    int   pos;
    // NOTE: every output gets a default before the search so no path leaves one unassigned,
    // which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, one transaction at a time,
// with busy/done timeouts reported back to the owning requester.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BUSY_TO = 8,
  parameter int DONE_TO = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_master_arbiter_if.master bus,
  output logic                 arb_busy,
  output logic [7:0]           err_count
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(max_int(BUSY_TO, DONE_TO) + 1);
  localparam logic [TIMER_W-1:0] BUSY_LAST = TIMER_W'(BUSY_TO - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST = TIMER_W'(DONE_TO - 1);

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [TIMER_W-1:0] timer;
  logic               err;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [CMD_W-1:0]   pick_cmd;
  logic               grant_ok;
  logic [NUM_REQ-1:0] owner_1h;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb pick_cmd = bus.req_data[int'(pick_idx)*CMD_W +: CMD_W];

  // Ready is gated by rst so the accept pulse reads 0 while reset is held.
  assign grant_ok      = (state == IDLE) && pick_any && !bus.m_busy && !rst;
  assign bus.req_ready = grant_ok ? pick_grant : '0;
  assign owner_1h      = NUM_REQ'(1) << owner;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      timer         <= '0;
      err           <= 1'b0;
      bus.m_start   <= 1'b0;
      bus.m_data_in <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      arb_busy      <= 1'b0;
      err_count     <= '0;
    end else begin
      bus.m_start   <= 1'b0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            owner         <= pick_idx;
            bus.m_data_in <= pick_cmd;
            bus.m_start   <= 1'b1;
            arb_busy      <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A done pulse before busy is seen belongs to nobody and is ignored here.
          if (bus.m_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer == BUSY_LAST) begin
            err           <= 1'b1;
            bus.rsp_valid <= owner_1h;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            state         <= RESP;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          // Done is tested first so a done coinciding with the timeout is not an error.
          if (bus.m_done) begin
            err           <= 1'b0;
            bus.rsp_valid <= owner_1h;
            bus.rsp_data  <= bus.m_data_out;
            bus.rsp_err   <= 1'b0;
            state         <= RESP;
          end else if (timer == DONE_LAST) begin
            err           <= 1'b1;
            bus.rsp_valid <= owner_1h;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            state         <= RESP;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
          rr_ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: a table of arbitration vectors plus hand-written
// timeout, tie, external-busy, saturation and reset sequences, checked through a scoreboard.
module tb_spi_master_arbiter;
  import spi_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int BUSY_TO = 8;
  localparam int DONE_TO = 1024;

  logic       clk;
  logic       rst;
  logic       arb_busy;
  logic [7:0] err_count;

  spi_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  spi_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .BUSY_TO (BUSY_TO),
    .DONE_TO (DONE_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .arb_busy  (arb_busy),
    .err_count (err_count)
  );

  typedef struct {
    logic [NUM_REQ-1:0] req;
    int                 owner;
    logic [7:0]         rdata;
    int                 busy_dly;
    int                 done_dly;
  } vec_t;

  typedef struct {
    int               owner;
    logic [CMD_W-1:0] cmd;
    logic [7:0]       data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CMD_W-1:0] cmd_of(input int i);
    case (i)
      0:       return 10'h2A5;
      1:       return 10'h13C;
      2:       return 10'h0F0;
      default: return 10'h3A1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Runs one transaction from IDLE. busy_dly/done_dly < 0 mean the master never raises
  // busy / never pulses done. Latency is counted in samples after the m_start sample.
  task automatic do_txn(input int owner, input logic [7:0] rdata, input int busy_dly,
                        input int done_dly, input bit early_done, output int waited);
    exp_t               e;
    exp_t               x;
    logic               exp_err;
    int                 exp_lat;
    logic [NUM_REQ-1:0] one_hot;
    bit                 bad_hold;
    bit                 got_rsp;
    exp_err = (busy_dly < 0) || (done_dly < 0);
    if (busy_dly < 0)      exp_lat = BUSY_TO + 1;
    else if (done_dly < 0) exp_lat = busy_dly + 1 + DONE_TO;
    else                   exp_lat = busy_dly + done_dly + 1;
    e.owner = owner;
    e.cmd   = cmd_of(owner);
    e.data  = exp_err ? 8'h00 : rdata;
    e.err   = exp_err;
    sb.push_back(e);

    #1;
    waited = 0;
    while (bus.req_ready == '0 && waited < 64) begin
      tick();
      waited++;
    end
    one_hot        = '0;
    one_hot[owner] = 1'b1;
    check("grant", bus.req_ready, one_hot);
    tick();
    check("m_start", bus.m_start, 1);
    check("m_data_in", bus.m_data_in, e.cmd);

    bad_hold = 1'b0;
    got_rsp  = 1'b0;
    for (int n = 0; n < BUSY_TO + DONE_TO + 64 && !got_rsp; n++) begin
      bus.m_done = 1'b0;
      if (early_done && n == 1) begin
        bus.m_done     = 1'b1;
        bus.m_data_out = 8'hFF;
      end
      bus.m_busy = (busy_dly >= 0) && (n >= busy_dly) &&
                   ((done_dly < 0) || (n < busy_dly + done_dly));
      if (busy_dly >= 0 && done_dly >= 0 && n == busy_dly + done_dly) begin
        bus.m_done     = 1'b1;
        bus.m_data_out = rdata;
      end
      tick();
      if (bus.m_start !== 1'b0 || bus.m_data_in !== e.cmd || bus.req_ready !== '0 ||
          arb_busy !== 1'b1)
        bad_hold = 1'b1;
      if (bus.rsp_valid != '0) begin
        got_rsp = 1'b1;
        if (sb.size() > 0) begin
          x              = sb.pop_front();
          one_hot        = '0;
          one_hot[x.owner] = 1'b1;
          check("rsp_valid", bus.rsp_valid, one_hot);
          check("rsp_data", bus.rsp_data, x.data);
          check("rsp_err", bus.rsp_err, x.err);
        end
        check("rsp_latency", n + 1, exp_lat);
      end
    end
    check("rsp_seen", got_rsp, 1);
    if (!got_rsp && sb.size() > 0) x = sb.pop_front();
    bus.m_done = 1'b0;
    bus.m_busy = 1'b0;
    check("hold", bad_hold, 0);
    tick();
    check("post_idle", {bus.rsp_valid, arb_busy}, 0);
  endtask

  initial begin
    int w;
    bus.req_valid  = '0;
    bus.req_data   = {cmd_of(3), cmd_of(2), cmd_of(1), cmd_of(0)};
    bus.m_busy     = 1'b0;
    bus.m_done     = 1'b0;
    bus.m_data_out = '0;
    rst            = 1'b1;
    repeat (3) tick();

    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_m_start", bus.m_start, 0);
    check("rst_m_data_in", bus.m_data_in, 0);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;

    // Fairness from rr_ptr=0, then single-requester and wrap-around picks.
    vecs[0]  = '{4'b1111, 0, 8'h10, 1, 1};
    vecs[1]  = '{4'b1111, 1, 8'h11, 2, 2};
    vecs[2]  = '{4'b1111, 2, 8'h12, 3, 3};
    vecs[3]  = '{4'b1111, 3, 8'h13, 1, 4};
    vecs[4]  = '{4'b1111, 0, 8'h14, 2, 1};
    vecs[5]  = '{4'b1111, 1, 8'h15, 3, 2};
    vecs[6]  = '{4'b1111, 2, 8'h16, 1, 3};
    vecs[7]  = '{4'b1111, 3, 8'h17, 2, 4};
    vecs[8]  = '{4'b0001, 0, 8'h3C, 2, 2};
    vecs[9]  = '{4'b0001, 0, 8'hC3, 1, 1};
    vecs[10] = '{4'b1000, 3, 8'h5D, 3, 2};
    vecs[11] = '{4'b0110, 1, 8'h66, 1, 3};
    vecs[12] = '{4'b0110, 2, 8'h99, 2, 1};
    vecs[13] = '{4'b0011, 0, 8'hA0, 3, 4};
    vecs[14] = '{4'b1010, 1, 8'h0B, 1, 2};
    vecs[15] = '{4'b1001, 3, 8'hE7, 2, 3};
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = vecs[i].req;
      do_txn(vecs[i].owner, vecs[i].rdata, vecs[i].busy_dly, vecs[i].done_dly, 1'b0, w);
    end

    // Busy timeout, then a normal transaction.
    bus.req_valid = 4'b0100;
    do_txn(2, 8'h77, -1, 0, 1'b0, w);
    check("err_count_busy_to", err_count, 1);
    do_txn(2, 8'h42, 2, 2, 1'b0, w);

    // Done coinciding with the done timeout.
    bus.req_valid = 4'b0001;
    do_txn(0, 8'h5A, 1, DONE_TO, 1'b0, w);
    check("err_count_tie", err_count, 1);

    // Done timeout.
    bus.req_valid = 4'b0010;
    do_txn(1, 8'h00, 2, -1, 1'b0, w);
    check("err_count_done_to", err_count, 2);

    // Busy arriving in the last WAIT_BUSY cycle, and an early done during WAIT_BUSY.
    bus.req_valid = 4'b1000;
    do_txn(3, 8'h81, BUSY_TO, 3, 1'b0, w);
    bus.req_valid = 4'b0001;
    do_txn(0, 8'h24, 4, 2, 1'b1, w);
    check("err_count_stable", err_count, 2);

    // External busy in IDLE, a request dropped before grant, then grant once busy clears.
    begin
      bit leak;
      leak          = 1'b0;
      bus.m_busy    = 1'b1;
      bus.req_valid = 4'b0100;
      repeat (4) begin
        #1;
        if (bus.req_ready !== '0 || bus.m_start !== 1'b0 || arb_busy !== 1'b0) leak = 1'b1;
        tick();
      end
      check("ext_busy_hold", leak, 0);
      leak          = 1'b0;
      bus.req_valid = '0;
      bus.m_busy    = 1'b0;
      repeat (3) begin
        #1;
        if (bus.req_ready !== '0 || bus.m_start !== 1'b0 || arb_busy !== 1'b0) leak = 1'b1;
        tick();
      end
      check("dropped_req", leak, 0);
      bus.req_valid = 4'b0010;
      bus.m_busy    = 1'b1;
      repeat (3) begin
        #1;
        if (bus.req_ready !== '0 || bus.m_start !== 1'b0) leak = 1'b1;
        tick();
      end
      check("ext_busy_hold2", leak, 0);
      bus.m_busy = 1'b0;
      do_txn(1, 8'h3E, 1, 2, 1'b0, w);
      check("ext_busy_release_wait", w, 0);
    end

    // err_count saturation: 254 more timeouts on top of 2.
    for (int i = 0; i < 254; i++) begin
      bus.req_valid = 4'b0001;
      do_txn(0, 8'h00, -1, 0, 1'b0, w);
    end
    check("err_count_sat", err_count, 255);

    // Reset while in WAIT_DONE abandons the transaction.
    bus.req_valid = 4'b0100;
    #1;
    check("pre_rst_grant", bus.req_ready, 4'b0100);
    tick();
    bus.m_busy = 1'b1;
    tick();
    tick();
    check("pre_rst_busy", arb_busy, 1);
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    tick();
    check("mid_rst_m_start", bus.m_start, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_arb_busy", arb_busy, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_m_data_in", bus.m_data_in, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    tick();
    check("mid_rst_rsp_valid2", bus.rsp_valid, 0);
    rst        = 1'b0;
    bus.m_busy = 1'b0;
    do_txn(0, 8'hA7, 2, 3, 1'b0, w);
    check("post_rst_err_count", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SPI master between NUM_REQ requesters.
- Accepts 10-bit command words, launches one master transaction at a time and watches the master's busy/done handshake.
- Returns the 8-bit received byte, or a timeout error, to the requester that owns the transaction.
- Sits between user/controller logic and the SPI master's start/data_in/busy/done/data_out interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TO, 8, max cycles from m_start to m_busy high before a timeout.
- DONE_TO, 1024, max cycles from m_busy high to m_done before a timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command pending; held until req_ready.
- req_data  in  NUM_REQ*10  flattened commands; requester i uses [10*i+9:10*i].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_data  out  8  received byte, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- m_start  out  1  start pulse to the SPI master.
- m_data_in  out  10  command word to the SPI master.
- m_busy  in  1  SPI master busy.
- m_done  in  1  SPI master done pulse.
- m_data_out  in  8  SPI master received byte.
- arb_busy  out  1  high whenever the FSM is not in IDLE.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE, rr_ptr=0, timer=0.
  - All outputs read 0 on the next edge, including m_start, m_data_in and err_count.
  - Reset mid-transaction abandons it: no rsp_valid is issued, and m_start drops on the next edge.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Acts only when some req_valid is set and m_busy=0.
  - Grants the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - Latches the index into owner and req_data[owner] into m_data_in.
  - Pulses req_ready[owner] in this cycle (combinational from the state and the grant), then goes to LAUNCH.
  - If m_busy=1, stays in IDLE and grants nothing.
- LAUNCH: m_start=1 for exactly one cycle; clear timer; go to WAIT_BUSY.
- WAIT_BUSY:
  - m_busy=1 → WAIT_DONE and clear timer.
  - Otherwise, when timer reaches BUSY_TO-1 → RESP with err.
- WAIT_DONE:
  - m_done=1 → capture m_data_out into rsp_data, err=0, go to RESP.
  - Otherwise, when timer reaches DONE_TO-1 → RESP with err=1 and rsp_data=0.
  - If m_done and the timeout coincide, m_done wins (no error).
- RESP:
  - rsp_valid[owner]=1 and rsp_err=err for one cycle.
  - If err, increment err_count, saturating at 255.
  - rr_ptr=(owner+1) mod NUM_REQ; go to IDLE.
- m_data_in holds the latched command stable from LAUNCH through RESP.
- Latency:
  - Grant at cycle T, m_start at T+1; the master raises m_busy by about T+3.
  - rsp_valid comes one cycle after m_done is seen.
  - Minimum gap between consecutive grants is 1 idle cycle after RESP.
- Fairness:
  - A continuously requesting source waits at most NUM_REQ-1 transactions.
  - A single active requester is granted back-to-back.
- Boundaries:
  - req_valid dropped before grant is ignored, with no error.
  - req_valid of the owner during the transaction is ignored.
  - m_done seen in WAIT_BUSY is ignored.
  - Timer width is $clog2(max(BUSY_TO,DONE_TO)+1); the timer saturates and never wraps.

Decomposition:
- Package spi_arb_pkg:
  - arb_state_e enum.
  - CMD_W=10 and RSP_W=8 constants.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr. Outputs: one-hot grant and index.
- The FSM, timer and datapath registers stay in spi_master_arbiter.

Test Plan:
- Single request: rst released, req_valid=4'b0001 with cmd 10'h2A5, master model returns 8'h3C → req_ready[0] pulses, m_start one cycle later with m_data_in=10'h2A5, then rsp_valid[0]=1, rsp_data=8'h3C, rsp_err=0.
- Fairness: all four requesters held valid for 8 transactions with rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; each rsp_valid goes only to its owner.
- Busy timeout: master never raises m_busy, BUSY_TO=8 → rsp_valid[owner] with rsp_err=1 and rsp_data=0 about 8 cycles after m_start; err_count=1; next request is served normally.
- Done/timeout tie: m_done asserted in the same cycle the DONE_TO timer expires → rsp_err=0, rsp_data=m_data_out, err_count unchanged.
- Reset mid-operation: rst=1 in WAIT_DONE → next edge shows m_start=0, rsp_valid=0, arb_busy=0 and err_count=0; after release, requester 0 is granted first.
- External busy: m_busy=1 while in IDLE with req_valid set → no req_ready and no m_start until m_busy=0, then grant on the following cycle.
